// File: rtl/down_count_timer.sv
// Loadable programmable down counter. It counts from a stored reload value to
// zero on enabled cycles, produces a one-cycle terminal-count pulse and toggles
// a divided-clock output on each expiry. It runs either one-shot or periodic.
// The reload value arrives over a valid/ready handshake that is held off while
// the counter runs, so the reload register never changes mid-run.
module down_count_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             mode,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc_pulse,
    output logic             div_out
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Decrement that floors at zero. The counter can never wrap below 0,
    // even if a caller reaches this with a zero operand.
    function automatic logic [WIDTH-1:0] dec_floor(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (v == '0) r = '0;
        else         r = v - ONE;
        return r;
    endfunction

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count_q, count_nxt;
    logic [WIDTH-1:0] reload_q, reload_nxt;
    logic             mode_q, mode_nxt;
    logic             tc_q, tc_nxt;
    logic             div_q, div_nxt;

    logic             in_run;
    logic             start_ok;
    logic             expire;
    logic             step;
    logic             load_fire;

    // Qualifiers shared by the next-state and datapath logic. stop overrides
    // start, enable and expiry in the same cycle.
    always_comb begin
        in_run    = (state == RUN);
        start_ok  = start && !stop && (reload_q != '0);
        expire    = in_run && !stop && enable && (count_q == '0);
        step      = in_run && !stop && enable && (count_q != '0);
        load_fire = load_valid && !in_run;
    end

    // State register, asynchronously cleared to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_ok) state_nxt = RUN;
            end
            RUN: begin
                if (stop)                 state_nxt = IDLE;
                else if (expire && !mode_q) state_nxt = DONE;
            end
            DONE: begin
                if (stop)          state_nxt = IDLE;
                else if (start_ok) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath next values: count, reload, latched mode, pulse and divider.
    // A start reads the reload register before a same-cycle load updates it.
    always_comb begin
        count_nxt  = count_q;
        mode_nxt   = mode_q;
        reload_nxt = reload_q;
        tc_nxt     = expire;
        div_nxt    = div_q ^ expire;

        if (!in_run && start_ok) begin
            count_nxt = reload_q;
            mode_nxt  = mode;
        end else if (expire) begin
            count_nxt = mode_q ? reload_q : '0;
        end else if (step) begin
            count_nxt = dec_floor(count_q);
        end

        if (load_fire) reload_nxt = load_value;
    end

    // Datapath registers. They are all cleared by the asynchronous reset, so a
    // reset in the middle of a run cannot leave a pending pulse behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            tc_q     <= 1'b0;
            div_q    <= 1'b0;
        end else begin
            count_q  <= count_nxt;
            reload_q <= reload_nxt;
            mode_q   <= mode_nxt;
            tc_q     <= tc_nxt;
            div_q    <= div_nxt;
        end
    end

    // Output decode. busy, done and load_ready come from the registered state.
    always_comb begin
        busy       = (state == RUN);
        done       = (state == DONE);
        load_ready = (state != RUN);
        count      = count_q;
        tc_pulse   = tc_q;
        div_out    = div_q;
    end

endmodule

// File: tb/tb_down_count_timer.sv
// Scoreboard bench for down_count_timer. The stimulus pushes hand-computed
// expected states (tagged with the cycle they should appear in) and expected
// terminal-count pulses. A separate monitor compares these on falling edges.
module tb_down_count_timer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_value;
    logic         mode;
    logic         start;
    logic         stop;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         tc_pulse;
    logic         div_out;

    down_count_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .mode       (mode),
        .start      (start),
        .stop       (stop),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .tc_pulse   (tc_pulse),
        .div_out    (div_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        logic [W-1:0] cnt;
        logic         busy;
        logic         done;
        logic         lr;
        logic         div;
    } st_t;

    typedef struct {
        int   cyc;
        logic div;
    } tc_t;

    st_t st_q[$];
    tc_t tc_q[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic exp_st(input int off, input logic [W-1:0] c, input logic b,
                          input logic d, input logic l, input logic v);
        st_t e;
        e.cyc = cyc + off; e.cnt = c; e.busy = b; e.done = d; e.lr = l; e.div = v;
        st_q.push_back(e);
    endtask

    task automatic exp_tc(input int off, input logic v);
        tc_t t;
        t.cyc = cyc + off; t.div = v;
        tc_q.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic lv, input logic [W-1:0] lval,
                         input logic md, input logic st, input logic sp);
        enable = en; load_valid = lv; load_value = lval;
        mode = md; start = st; stop = sp;
    endtask

    // Monitor: compare the state snapshot due this cycle and every tc pulse.
    always @(negedge clk) begin : monitor
        st_t e;
        tc_t t;
        while (st_q.size() > 0 && st_q[0].cyc < cyc) begin
            e = st_q.pop_front();
            checks++; failures++;
            $display("FAIL state_missed cyc=%0d expected count=%0d", e.cyc, e.cnt);
        end
        if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
            e = st_q.pop_front();
            checks++;
            if ({count, busy, done, load_ready, div_out} !== {e.cnt, e.busy, e.done, e.lr, e.div}) begin
                failures++;
                $display("FAIL state cyc=%0d got count=%0d busy=%b done=%b load_ready=%b div_out=%b, expected count=%0d busy=%b done=%b load_ready=%b div_out=%b",
                         cyc, count, busy, done, load_ready, div_out, e.cnt, e.busy, e.done, e.lr, e.div);
            end
        end
        while (tc_q.size() > 0 && tc_q[0].cyc < cyc) begin
            t = tc_q.pop_front();
            checks++; failures++;
            $display("FAIL tc_missing got no pulse at cyc=%0d, expected pulse", t.cyc);
        end
        if (tc_pulse !== 1'b0) begin
            checks++;
            if (tc_q.size() == 0 || tc_q[0].cyc != cyc) begin
                failures++;
                $display("FAIL tc_unexpected got tc_pulse=%b at cyc=%0d, expected 0", tc_pulse, cyc);
            end else begin
                t = tc_q.pop_front();
                if (div_out !== t.div) begin
                    failures++;
                    $display("FAIL tc_div cyc=%0d got div_out=%b, expected %b", cyc, div_out, t.div);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [W-1:0] tbl [10];
        tbl = '{8'd4, 8'd3, 8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0, 8'd4};

        // Reset state, checked while rst is still asserted and after release.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick(); tick();
        exp_st(0, 0, 0, 0, 1, 0);
        tick();
        rst = 1'b0;
        exp_st(1, 0, 0, 0, 1, 0);
        tick();

        // Periodic N=3, enable always high: 3,2,1,0 repeating, pulse every 4.
        drive(0, 1, 3, 0, 0, 0); tick();
        drive(1, 0, 0, 1, 1, 0);
        for (int k = 0; k <= 8; k++)
            exp_st(k + 1, W'(3 - (k % 4)), 1, 0, 0, (k >= 4 && k < 8));
        exp_tc(5, 1); exp_tc(9, 0); exp_tc(13, 1);
        tick();
        drive(1, 0, 0, 1, 0, 0);
        repeat (12) tick();
        drive(1, 0, 0, 1, 0, 1);
        exp_st(1, 3, 0, 0, 1, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0); tick();

        // One-shot N=2; mode flipped mid-run must not matter.
        drive(0, 1, 2, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 1, 0);
        exp_st(1, 2, 1, 0, 0, 1);
        exp_st(2, 1, 1, 0, 0, 1);
        exp_st(3, 0, 1, 0, 0, 1);
        for (int k = 4; k <= 8; k++) exp_st(k, 0, 0, 1, 1, 0);
        exp_tc(4, 0);
        tick();
        drive(1, 0, 0, 1, 0, 0);
        repeat (7) tick();
        drive(0, 0, 0, 0, 0, 1);
        exp_st(1, 0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0); tick();

        // Periodic N=4 with enable alternating: expiry every 10 clocks.
        drive(0, 1, 4, 0, 0, 0); tick();
        drive(1, 0, 0, 1, 1, 0);
        for (int m = 0; m < 20; m++)
            exp_st(m + 1, tbl[m % 10], 1, 0, 0, (m >= 9 && m < 19));
        exp_tc(10, 1); exp_tc(20, 0);
        tick();
        for (int j = 0; j < 19; j++) begin
            drive((j % 2) == 0, 0, 0, 1, 0, 0);
            tick();
        end
        drive(0, 0, 0, 1, 0, 1);
        exp_st(1, 4, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0); tick();

        // N=5, stop together with enable at count=2: holds 2, no pulse.
        drive(0, 1, 5, 0, 0, 0); tick();
        drive(1, 0, 0, 1, 1, 0);
        exp_st(1, 5, 1, 0, 0, 0);
        exp_st(2, 4, 1, 0, 0, 0);
        exp_st(3, 3, 1, 0, 0, 0);
        exp_st(4, 2, 1, 0, 0, 0);
        tick();
        drive(1, 0, 0, 1, 0, 0);
        repeat (3) tick();
        drive(1, 0, 0, 1, 0, 1);
        exp_st(1, 2, 0, 0, 1, 0);
        tick();
        drive(1, 0, 0, 1, 0, 0);
        exp_st(1, 2, 0, 0, 1, 0);
        tick();

        // Same-cycle load and start uses the old reload; loads blocked in RUN.
        drive(0, 1, 7, 0, 0, 0); tick();
        drive(0, 1, 9, 1, 1, 0);
        exp_st(1, 7, 1, 0, 0, 0);
        tick();
        drive(0, 1, 11, 1, 0, 0);
        exp_st(1, 7, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 0, 1);
        exp_st(1, 7, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 1, 1, 0);
        exp_st(1, 9, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 0, 1);
        exp_st(1, 9, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 1, 1, 1);
        exp_st(1, 9, 0, 0, 1, 0);
        tick();

        // Start with reload==0 is ignored.
        drive(0, 1, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 1, 1, 0);
        exp_st(1, 9, 0, 0, 1, 0);
        tick();

        // Asynchronous reset mid-run at count=5.
        drive(0, 1, 6, 0, 0, 0); tick();
        drive(1, 0, 0, 1, 1, 0);
        exp_st(1, 6, 1, 0, 0, 0);
        tick();
        drive(1, 0, 0, 1, 0, 0);
        tick();
        rst = 1'b1;
        exp_st(0, 0, 0, 0, 1, 0);
        tick(); tick();
        rst = 1'b0;
        exp_st(1, 0, 0, 0, 1, 0);
        tick();
        // Reload register was cleared too, so this start is ignored.
        drive(1, 0, 0, 1, 1, 0);
        exp_st(1, 0, 0, 0, 1, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        repeat (4) tick();
        @(negedge clk);
        #1;

        checks++;
        if (st_q.size() != 0 || tc_q.size() != 0) begin
            failures++;
            $display("FAIL leftover got state_q=%0d tc_q=%0d pending, expected 0 and 0", st_q.size(), tc_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
